// File: rtl/fetch_frontend_if.sv
// Bus bundle between the fetch front end and its environment: i-memory handshake,
// redirect inputs and the instruction-queue head.
interface fetch_frontend_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IQ_DEPTH = 8
);
  localparam int unsigned CntW = $clog2(IQ_DEPTH) + 1;

  logic             i_mem_resp;
  logic [WIDTH-1:0] i_mem_rdata;
  logic             i_mem_read;
  logic [WIDTH-1:0] i_mem_address;
  logic             pred_valid;
  logic [WIDTH-1:0] pred_pc;
  logic             flush_valid;
  logic [WIDTH-1:0] flush_pc;
  logic             deq;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [CntW-1:0]  count;
  logic             full;

  modport master (
    input  i_mem_resp, i_mem_rdata, pred_valid, pred_pc, flush_valid, flush_pc, deq,
    output i_mem_read, i_mem_address, out_valid, out_instr, out_pc, count, full
  );

  modport slave (
    output i_mem_resp, i_mem_rdata, pred_valid, pred_pc, flush_valid, flush_pc, deq,
    input  i_mem_read, i_mem_address, out_valid, out_instr, out_pc, count, full
  );
endinterface

// File: rtl/fetch_frontend.sv
// Instruction-fetch front end: PC generation, single-outstanding i-memory request and
// a circular queue of {pc, instr} pairs feeding decode.
module fetch_frontend #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     IQ_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h00000060
) (
  input logic              clk,
  input logic              rst,
  fetch_frontend_if.master bus
);
  localparam int unsigned PtrW = $clog2(IQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(IQ_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] iq_pc_q    [IQ_DEPTH];
  logic [WIDTH-1:0] iq_instr_q [IQ_DEPTH];

  logic             deq_eff;
  logic             enq;
  logic [WIDTH-1:0] next_pc;
  logic [CntW-1:0]  count_after;

  assign deq_eff     = bus.deq & (count_q != '0);
  assign next_pc     = bus.pred_valid ? bus.pred_pc : fetch_addr_q + WIDTH'(4);
  assign count_after = count_q + CntW'(1) - CntW'(deq_eff);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    enq          = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A response here is illegal and is ignored.
        if (bus.flush_valid) begin
          pc_d = bus.flush_pc;
        end else if (count_q + CntW'(deq_eff) < Depth) begin
          state_d      = StReq;
          fetch_addr_d = pc_q;
        end
      end
      StReq: begin
        if (bus.i_mem_resp) begin
          if (bus.flush_valid) begin
            pc_d    = bus.flush_pc;
            state_d = StIdle;
          end else begin
            enq  = 1'b1;
            pc_d = next_pc;
            if (count_after < Depth) begin
              fetch_addr_d = next_pc;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (bus.flush_valid) begin
          pc_d    = bus.flush_pc;
          state_d = StDrop;
        end
      end
      StDrop: begin
        // Hold the stale request until memory answers, then throw the data away.
        if (bus.flush_valid) pc_d = bus.flush_pc;
        if (bus.i_mem_resp) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PtrW'(1);
      if (deq_eff) head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(enq) - CntW'(deq_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      iq_pc_q[tail_q]    <= fetch_addr_q;
      iq_instr_q[tail_q] <= bus.i_mem_rdata;
    end
  end

  assign bus.i_mem_read    = (state_q != StIdle);
  assign bus.i_mem_address = fetch_addr_q;
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_pc        = iq_pc_q[head_q];
  assign bus.out_instr     = iq_instr_q[head_q];
  assign bus.count         = count_q;
  assign bus.full          = (count_q == Depth);

  resp_in_idle_a: assert property (@(posedge clk) disable iff (rst)
    !(state_q == StIdle && bus.i_mem_resp));
endmodule

// File: tb/tb_fetch_frontend.sv
// Scenario bench for fetch_frontend: expected {pc, instr} pairs are queued as responses
// are driven and compared against the queue head as entries are dequeued.
module tb_fetch_frontend;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_checks = 0;
  int     n_fails = 0;
  entry_t sb[$];

  fetch_frontend_if #(.WIDTH(32), .IQ_DEPTH(8)) bus ();

  fetch_frontend #(
    .WIDTH   (32),
    .IQ_DEPTH(8),
    .RESET_PC(32'h00000060)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_mem_resp  = 1'b0;
    bus.i_mem_rdata = '0;
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.flush_valid = 1'b0;
    bus.flush_pc    = '0;
    bus.deq         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    sb.delete();
    rst = 1'b0;
    step();
  endtask

  // Wait (bounded) for a request, check its address, answer it for one cycle.
  task automatic respond(input logic [31:0] exp_addr, input logic [31:0] instr,
                         input logic pv, input logic [31:0] ppc);
    int t = 0;
    entry_t e;
    while (bus.i_mem_read !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    n_checks++;
    if (bus.i_mem_read !== 1'b1) begin
      n_fails++;
      $display("FAIL resp_wait: i_mem_read=%b want 1 (addr %h)", bus.i_mem_read, exp_addr);
    end
    n_checks++;
    if (bus.i_mem_address !== exp_addr) begin
      n_fails++;
      $display("FAIL resp_addr: got %h want %h", bus.i_mem_address, exp_addr);
    end
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = instr;
    bus.pred_valid  = pv;
    bus.pred_pc     = ppc;
    e.pc    = exp_addr;
    e.instr = instr;
    sb.push_back(e);
    step();
    bus.i_mem_resp = 1'b0;
    bus.pred_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    entry_t e;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
        n_fails++;
        $display("FAIL drain_valid: out_valid=%b sb_size=%0d want 1 and >0",
                 bus.out_valid, sb.size());
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          n_fails++;
          $display("FAIL drain_head: got pc=%h instr=%h want pc=%h instr=%h",
                   bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      bus.deq = 1'b1;
      step();
    end
    bus.deq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    n_checks++;
    if ({bus.i_mem_read, bus.out_valid, bus.full} !== 3'b000 || bus.count !== 4'd0) begin
      n_fails++;
      $display("FAIL reset_state: read/valid/full=%b%b%b count=%0d want 000 and 0",
               bus.i_mem_read, bus.out_valid, bus.full, bus.count);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h60) begin
      n_fails++;
      $display("FAIL reset_first_req: read=%b addr=%h want 1 and 00000060",
               bus.i_mem_read, bus.i_mem_address);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step();
      respond(32'h60 + 32'(4 * i), 32'h13 | (32'(i) << 20), 1'b0, '0);
    end
    n_checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.i_mem_read !== 1'b0) begin
      n_fails++;
      $display("FAIL fill_full: count=%0d full=%b read=%b want 8 1 0",
               bus.count, bus.full, bus.i_mem_read);
    end
    step();
    step();
    step();
    n_checks++;
    if (bus.i_mem_read !== 1'b0 || bus.out_pc !== 32'h60) begin
      n_fails++;
      $display("FAIL fill_hold: read=%b out_pc=%h want 0 and 00000060",
               bus.i_mem_read, bus.out_pc);
    end
  endtask

  task automatic test_deq_wrap();
    drain(3);
    n_checks++;
    if (bus.count !== 4'd5 || bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h80) begin
      n_fails++;
      $display("FAIL wrap_refill: count=%0d read=%b addr=%h want 5 1 00000080",
               bus.count, bus.i_mem_read, bus.i_mem_address);
    end
    respond(32'h80, 32'hA0000093, 1'b0, '0);
    respond(32'h84, 32'hA1000093, 1'b0, '0);
    respond(32'h88, 32'hA2000093, 1'b0, '0);
    n_checks++;
    if (bus.count !== 4'd8 || bus.i_mem_read !== 1'b0) begin
      n_fails++;
      $display("FAIL wrap_full: count=%0d read=%b want 8 0", bus.count, bus.i_mem_read);
    end
    drain(8);
    n_checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL wrap_empty: count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_predict();
    do_reset();
    respond(32'h60, 32'h11111113, 1'b0, '0);
    respond(32'h64, 32'h22222213, 1'b1, 32'h200);
    respond(32'h200, 32'h33333313, 1'b0, '0);
    n_checks++;
    if (bus.count !== 4'd3) begin
      n_fails++;
      $display("FAIL pred_count: got %0d want 3", bus.count);
    end
    drain(3);
  endtask

  task automatic test_flush_pending();
    do_reset();
    for (int i = 0; i < 4; i++) respond(32'h60 + 32'(4 * i), 32'h500 + 32'(i), 1'b0, '0);
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h400;
    step();
    bus.flush_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h70 || bus.out_valid !== 1'b0
          || bus.count !== 4'd0) begin
        n_fails++;
        $display("FAIL drop_hold: read=%b addr=%h valid=%b count=%0d want 1 00000070 0 0",
                 bus.i_mem_read, bus.i_mem_address, bus.out_valid, bus.count);
      end
      step();
    end
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = 32'hDEADBEEF;
    step();
    bus.i_mem_resp = 1'b0;
    n_checks++;
    if (bus.i_mem_read !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
      n_fails++;
      $display("FAIL drop_discard: read=%b valid=%b count=%0d want 0 0 0",
               bus.i_mem_read, bus.out_valid, bus.count);
    end
    step();
    n_checks++;
    if (bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h400 || bus.out_valid !== 1'b0)
    begin
      n_fails++;
      $display("FAIL drop_next: read=%b addr=%h valid=%b want 1 00000400 0",
               bus.i_mem_read, bus.i_mem_address, bus.out_valid);
    end
  endtask

  task automatic test_flush_resp_deq();
    do_reset();
    for (int i = 0; i < 3; i++) respond(32'h60 + 32'(4 * i), 32'h700 + 32'(i), 1'b0, '0);
    n_checks++;
    if (bus.count !== 4'd3) begin
      n_fails++;
      $display("FAIL frd_pre_count: got %0d want 3", bus.count);
    end
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = 32'hBAD00013;
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h400;
    bus.deq         = 1'b1;
    step();
    clear_inputs();
    sb.delete();
    n_checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.i_mem_read !== 1'b0) begin
      n_fails++;
      $display("FAIL frd_clear: count=%0d valid=%b read=%b want 0 0 0",
               bus.count, bus.out_valid, bus.i_mem_read);
    end
    step();
    n_checks++;
    if (bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h400) begin
      n_fails++;
      $display("FAIL frd_next: read=%b addr=%h want 1 00000400",
               bus.i_mem_read, bus.i_mem_address);
    end
  endtask

  task automatic test_double_flush();
    do_reset();
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h400;
    step();
    bus.flush_pc = 32'h800;
    step();
    bus.flush_valid = 1'b0;
    n_checks++;
    if (bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h60) begin
      n_fails++;
      $display("FAIL dbl_hold: read=%b addr=%h want 1 00000060",
               bus.i_mem_read, bus.i_mem_address);
    end
    step();
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = 32'hCAFE0013;
    step();
    bus.i_mem_resp = 1'b0;
    n_checks++;
    if (bus.i_mem_read !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL dbl_discard: read=%b valid=%b want 0 0", bus.i_mem_read, bus.out_valid);
    end
    step();
    n_checks++;
    if (bus.i_mem_read !== 1'b1 || bus.i_mem_address !== 32'h800) begin
      n_fails++;
      $display("FAIL dbl_next: read=%b addr=%h want 1 00000800",
               bus.i_mem_read, bus.i_mem_address);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fill();
    test_deq_wrap();
    test_predict();
    test_flush_pending();
    test_flush_resp_deq();
    test_double_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
